// File: rtl/hdpldadapt_cmn_cp_ctrl.sv
// Round-robin control-word sequencer driving master_out of the control-plane distribution chain.
// Latency: grant 1 cycle after req, ack r_settle_cnt+2 cycles after req; requester holds req until ack.
// Optional settle watchdog enabled by HDPLDADAPT_CP_CTRL_TIMEOUT_EN.
module hdpldadapt_cmn_cp_ctrl #(
  parameter int WIDTH           = 1,
  parameter int NUM_REQ         = 2,
  parameter int CNT_WIDTH       = 5,
  parameter bit ASYNC_RESET_VAL = 1'b0,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srst_n,
  input  logic                       data_enable,
  input  logic                       r_ctrl_en,
  input  logic [CNT_WIDTH-1:0]       r_settle_cnt,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           master_out,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]    r_ack, w_ack_nxt;
  logic [WIDTH-1:0]      r_mo, w_mo_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [IDXW-1:0]       r_win, w_win_nxt;
  logic [IDXW-1:0]       r_rr, w_rr_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [IDXW-1:0]       w_pick;
  logic                  w_wd_hit;

  // First requester at or above the rr pointer, wrapping past NUM_REQ-1.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDXW-1:0]    p);
    logic [IDXW:0]   s;
    logic [IDXW-1:0] w;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      s = {1'b0, p} + (IDXW+1)'(i);
      if (s >= (IDXW+1)'(NUM_REQ)) s = s - (IDXW+1)'(NUM_REQ);
      if (r[s[IDXW-1:0]]) w = s[IDXW-1:0];
    end
    return w;
  endfunction

  assign w_pick = rr_pick(req, r_rr);

`ifdef HDPLDADAPT_CP_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wd, w_wd_nxt;
  logic          r_to_err, w_to_err_nxt;

  assign w_wd_hit = (r_wd == TW'(TIMEOUT - 1));

  // Watchdog is zero outside SETTLE, so it starts from zero on every entry.
  always_comb begin
    w_wd_nxt     = '0;
    w_to_err_nxt = r_to_err;
    if (r_state == SETTLE) begin
      w_wd_nxt = r_wd + 1'b1;
      if (r_cnt != '0 && w_wd_hit) w_to_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd     <= '0;
      r_to_err <= 1'b0;
    end else if (!srst_n) begin
      r_wd     <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_wd     <= w_wd_nxt;
      r_to_err <= w_to_err_nxt;
    end
  end

  assign timeout_err = r_to_err;
`else
  assign w_wd_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = '0;
    w_mo_nxt    = r_mo;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        if (r_ctrl_en && (|req)) begin
          w_state_nxt = SETTLE;
          w_gnt_nxt   = NUM_REQ'(1) << w_pick;
          w_mo_nxt    = req_data[int'(w_pick)*WIDTH +: WIDTH];
          w_cnt_nxt   = r_settle_cnt;
          w_win_nxt   = w_pick;
        end
      end
      SETTLE: begin
        if (r_cnt == '0 || w_wd_hit) begin
          w_state_nxt = ACK;
          w_ack_nxt   = r_gnt;
        end else if (data_enable) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_rr_nxt    = (int'(r_win) == NUM_REQ - 1) ? '0 : r_win + 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_mo    <= {WIDTH{ASYNC_RESET_VAL}};
      r_cnt   <= '0;
      r_win   <= '0;
      r_rr    <= '0;
      r_busy  <= 1'b0;
    end else if (!srst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_mo    <= {WIDTH{ASYNC_RESET_VAL}};
      r_cnt   <= '0;
      r_win   <= '0;
      r_rr    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_mo    <= w_mo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_win   <= w_win_nxt;
      r_rr    <= w_rr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign ack        = r_ack;
  assign master_out = r_mo;
  assign busy       = r_busy;

endmodule

// File: tb/tb_hdpldadapt_cmn_cp_ctrl.sv
// Scoreboard bench for hdpldadapt_cmn_cp_ctrl: directed stimulus queues expected acks,
// a negedge monitor pops and checks them; direct checks cover reset, grant and idle states.
module tb_hdpldadapt_cmn_cp_ctrl;

  localparam int W  = 4;
  localparam int NR = 2;
  localparam int CW = 5;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n, srst_n, de, en;
  logic [CW-1:0]   sc;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] rd;
  logic [NR-1:0]   gnt, ack;
  logic [W-1:0]    mo;
  logic            busy, to_err;

  always #5 clk = ~clk;

  hdpldadapt_cmn_cp_ctrl #(
    .WIDTH(W), .NUM_REQ(NR), .CNT_WIDTH(CW), .ASYNC_RESET_VAL(1'b1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .srst_n(srst_n), .data_enable(de), .r_ctrl_en(en),
    .r_settle_cnt(sc), .req(req), .req_data(rd), .gnt(gnt), .ack(ack),
    .master_out(mo), .busy(busy), .timeout_err(to_err)
  );

  typedef struct {
    logic [NR-1:0] a;
    logic [W-1:0]  mo;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c, k;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every ack pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ack != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_vec", 32'(ack), 32'(mon_e.a));
        chk("ack_gnt", 32'(gnt), 32'(mon_e.a));
        chk("ack_word", 32'(mo), 32'(mon_e.mo));
        chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    rst_n = 1'b0; srst_n = 1'b1; de = 1'b0; en = 1'b0; sc = '0; req = '0; rd = '0;
    tick(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mo", 32'(mo), 32'hF);
    chk("rst_to", 32'(to_err), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Single request, settle 3; req and data change after load must not matter.
    rd = {4'hA, 4'h5}; en = 1'b1; de = 1'b1; sc = 5'd3; req = 2'b01; c = cyc;
    exp_q.push_back('{2'b01, 4'h5, c + 5});
    tick(1);
    chk("single_gnt", 32'(gnt), 32'b01);
    chk("single_mo", 32'(mo), 32'h5);
    chk("single_busy1", 32'(busy), 32'd1);
    req = 2'b00; rd = {4'hA, 4'h3};
    tick(4);
    chk("single_busy5", 32'(busy), 32'd1);
    tick(1);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_gnt", 32'(gnt), 32'd0);
    chk("single_hold_mo", 32'(mo), 32'h5);

    // Round robin with both requesting; pointer now at 1.
    sc = 5'd0; req = 2'b11; c = cyc;
    exp_q.push_back('{2'b10, 4'hA, c + 2});
    exp_q.push_back('{2'b01, 4'h3, c + 5});
    exp_q.push_back('{2'b10, 4'hA, c + 8});
    exp_q.push_back('{2'b01, 4'h3, c + 11});
    tick(10);
    chk("rr_last_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    tick(3);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Stalled data_enable: pointer at 1, req0 wins by wrap-around.
    rd[3:0] = 4'h6; sc = 5'd2; de = 1'b0; req = 2'b01;
    tick(1);
    chk("stall_gnt", 32'(gnt), 32'b01);
    chk("stall_mo", 32'(mo), 32'h6);
    req = 2'b00; rd[3:0] = 4'h9;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("stall_mo_hold", 32'(mo), 32'h6);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    de = 1'b1; k = cyc;
    exp_q.push_back('{2'b01, 4'h6, k + 3});
    tick(4);
    chk("stall_done", 32'(busy), 32'd0);

    // Synchronous reset mid-SETTLE, then pointer must be back at 0.
    req = 2'b10; sc = 5'd5;
    tick(2);
    chk("srst_pre_gnt", 32'(gnt), 32'b10);
    srst_n = 1'b0;
    tick(1);
    chk("srst_gnt", 32'(gnt), 32'd0);
    chk("srst_busy", 32'(busy), 32'd0);
    chk("srst_mo", 32'(mo), 32'hF);
    srst_n = 1'b1; req = 2'b11; sc = 5'd0; c = cyc;
    exp_q.push_back('{2'b01, 4'h9, c + 2});
    tick(1);
    chk("srst_rr_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    tick(3);

    // Asynchronous reset between edges clears outputs without a clock.
    req = 2'b10; sc = 5'd5;
    tick(2);
    chk("arst_pre_gnt", 32'(gnt), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_mo", 32'(mo), 32'hF);
    #1 rst_n = 1'b1; req = 2'b00;
    tick(1);
    req = 2'b11; sc = 5'd0; c = cyc;
    exp_q.push_back('{2'b01, 4'h9, c + 2});
    tick(1);
    chk("arst_rr_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    tick(3);

    // Disabled: no grant; enable grants next cycle; dropping enable mid-flight still acks.
    en = 1'b0; req = 2'b01; sc = 5'd1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("dis_gnt", 32'(gnt), 32'd0);
    end
    en = 1'b1; c = cyc;
    exp_q.push_back('{2'b01, 4'h9, c + 3});
    tick(1);
    chk("en_gnt", 32'(gnt), 32'b01);
    en = 1'b0;
    tick(4);
    chk("en_drop_busy", 32'(busy), 32'd0);
    chk("en_drop_nogrant", 32'(gnt), 32'd0);
    req = 2'b00;

    // Settle watchdog with data_enable stuck low.
    en = 1'b1; sc = 5'd5; de = 1'b0; req = 2'b01; c = cyc;
`ifdef HDPLDADAPT_CP_CTRL_TIMEOUT_EN
    exp_q.push_back('{2'b01, 4'h9, c + 17});
    tick(1);
    req = 2'b00;
    tick(17);
    chk("to_err_set", 32'(to_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    tick(5);
    chk("to_err_sticky", 32'(to_err), 32'd1);
    srst_n = 1'b0;
    tick(1);
    srst_n = 1'b1;
    chk("to_err_clr", 32'(to_err), 32'd0);
`else
    tick(1);
    req = 2'b00;
    tick(40);
    chk("nto_busy", 32'(busy), 32'd1);
    chk("nto_gnt", 32'(gnt), 32'b01);
    chk("nto_err", 32'(to_err), 32'd0);
    srst_n = 1'b0;
    tick(1);
    srst_n = 1'b1;
    chk("nto_clr_busy", 32'(busy), 32'd0);
`endif

    tick(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdpldadapt_cmn_cp_ctrl.md
Name: hdpldadapt_cmn_cp_ctrl

Overview:
Master-side sequencer for the control-plane distribution chain. It arbitrates round-robin between NUM_REQ requesters that want to update the bonded control word, and drives the winning word onto master_out, which feeds the master_in of the master channel's distribution stage. It then holds the word stable for a programmable number of data-enabled cycles so the word reaches every channel, and acknowledges the requester only after that.

Parameters:
WIDTH, 1, control word width
NUM_REQ, 2, number of requesters (2..8)
CNT_WIDTH, 5, settle counter width
ASYNC_RESET_VAL, 0, reset value per bit of master_out
TIMEOUT, 255, settle watchdog limit in clk cycles (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active low
srst_n  in  1  sync reset, active low
data_enable  in  1  chain data enable; the settle counter advances only when it is high
r_ctrl_en  in  1  CRAM; 0 blocks new grants
r_settle_cnt  in  CNT_WIDTH  CRAM; data-enabled cycles to hold before ack
req  in  NUM_REQ  per-requester request level
req_data  in  NUM_REQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
gnt  out  NUM_REQ  one-hot grant, high from load through ack
ack  out  NUM_REQ  one-cycle completion pulse
master_out  out  WIDTH  to master_in of the distribution chain
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n low async, or srst_n low at posedge): state=IDLE, gnt=0, ack=0, busy=0, master_out={WIDTH{ASYNC_RESET_VAL}}, rr pointer=0, counter=0, timeout_err=0.
- Reset during any state aborts the transaction. No ack is issued.
- All outputs are registered.
- FSM states: IDLE, SETTLE, ACK.
- IDLE: if r_ctrl_en && |req:
  - Winner is the first requester with req high, searching from rr_ptr upward with wrap-around past NUM_REQ-1.
  - Next cycle: gnt[winner]=1, master_out=req_data[winner], cnt=r_settle_cnt, state=SETTLE.
- SETTLE:
  - If cnt==0, go to ACK.
  - Else if data_enable, cnt decrements.
  - Else cnt holds.
- ACK: ack[winner]=1 for exactly one cycle, gnt cleared, rr_ptr=(winner+1) mod NUM_REQ, state=IDLE.
- Latency: with req seen in cycle 0 and data_enable held high, gnt rises in cycle 1 and ack is high in cycle r_settle_cnt+2. With r_settle_cnt=0, ack is in cycle 2.
- master_out keeps the last loaded word after ack, until the next load or reset.
- req dropped during SETTLE is ignored; the transaction completes and is acked.
- A req still high in IDLE after its ack is treated as a new request and is subject to rr fairness.
- r_ctrl_en dropped mid-transaction: the current transaction completes; no new grant is issued.
- req_data changes after load are ignored; the word is latched.
- r_settle_cnt is sampled only at load.
- IDLE can grant on the cycle after ACK. Back-to-back throughput is one word per r_settle_cnt+3 cycles.

Optional Feature:
Macro HDPLDADAPT_CP_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counts clk cycles in SETTLE and clears on entry to SETTLE.
  - On reaching TIMEOUT with cnt!=0, the FSM forces the ACK state (normal ack pulse) and sets timeout_err=1.
  - timeout_err stays set until rst_n or srst_n.
- Not defined: no watchdog logic; timeout_err is tied 0; SETTLE waits indefinitely for data_enable.

Test Plan:
- Single request: req=2'b01, req_data[0]=1, r_settle_cnt=3, data_enable=1. Expect gnt=01 in cycle 1, master_out=1 in cycle 1, ack[0] only in cycle 5, busy high cycles 1-5.
- Round-robin: req=2'b11 held continuously, r_settle_cnt=0. Expect grants alternating 0,1,0,1, each ack 3 cycles apart.
- Stalled enable: r_settle_cnt=2, data_enable low for 10 SETTLE cycles then high. Expect ack exactly 3 cycles after data_enable rises, master_out stable throughout.
- Reset mid-operation: pulse srst_n low during SETTLE. Expect next cycle gnt=0, no ack, master_out=ASYNC_RESET_VAL, rr_ptr=0. Repeat with async rst_n asserted between clock edges: outputs clear immediately.
- Disable: r_ctrl_en=0 with req=2'b01. Expect no gnt for 20 cycles. Set r_ctrl_en=1: gnt in the next cycle. Drop r_ctrl_en during SETTLE: ack still issued.
- With HDPLDADAPT_CP_CTRL_TIMEOUT_EN, TIMEOUT=16, data_enable=0, r_settle_cnt=5: expect forced ack after 16 SETTLE cycles and timeout_err=1 sticky until srst_n. Without the macro: no ack, timeout_err=0.
